// File: rtl/subtrator_serial.sv
// Bit-serial two's-complement subtractor: diferenca = a - b, LSB first, WIDTH+1 cycles per result.
// Optional overflow flag port `ovf` is built only when SUBTRATOR_OVF_EN is defined.
module subtrator_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   diferenca,
`ifdef SUBTRATOR_OVF_EN
  output logic             ovf,
`endif
  output logic             sinal
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_reg;
  logic [WIDTH:0]  ra_reg;
  logic [WIDTH:0]  rb_reg;
  logic [WIDTH:0]  acc_reg;
  logic            br_reg;
  logic [CW-1:0]   cnt_reg;

  logic            x_bit;
  logic            y_bit;
  logic            d_bit;
  logic            br_next;
  logic [WIDTH:0]  acc_next;

  // One full-subtractor cell; the accumulator fills from the top so bit 0 lands last.
  always_comb begin
    x_bit    = ra_reg[0];
    y_bit    = rb_reg[0];
    d_bit    = x_bit ^ y_bit ^ br_reg;
    br_next  = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & br_reg);
    acc_next = {d_bit, acc_reg[WIDTH:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ra_reg    <= '0;
      rb_reg    <= '0;
      acc_reg   <= '0;
      br_reg    <= 1'b0;
      cnt_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      diferenca <= '0;
      sinal     <= 1'b0;
`ifdef SUBTRATOR_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            ra_reg    <= {a[WIDTH-1], a};
            rb_reg    <= {b[WIDTH-1], b};
            acc_reg   <= '0;
            br_reg    <= 1'b0;
            cnt_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          ra_reg  <= ra_reg >> 1;
          rb_reg  <= rb_reg >> 1;
          br_reg  <= br_next;
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg + CW'(1);
          if (cnt_reg == CW'(WIDTH)) begin
            diferenca <= acc_next;
            sinal     <= acc_next[WIDTH];
`ifdef SUBTRATOR_OVF_EN
            ovf       <= acc_next[WIDTH] ^ acc_next[WIDTH-1];
`endif
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          done      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          done      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
